// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Optional divider support is selected by the ALU_DIV_EN macro in the top module.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_MUL  = 3'd1,
      OP_AND  = 3'd2,
      OP_XOR  = 3'd3,
      OP_SUB  = 3'd4,
      OP_OR   = 3'd5,
      OP_DIV  = 3'd6,
      OP_RSVD = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Bit positions inside the {N, Z, C, V} flags vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle between the operand bank and the result stage.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic             error;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flags, error
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flags, error
   );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: first partial product on start, then one
// multiplier bit per cycle; done pulses once the full product is ready.
module alu_seq_mul #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic               done_r;

   // Bit 0 is consumed on start so the last bit lands WIDTH-1 cycles later
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         cnt_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_r  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_r <= b >> 1;
            cnt_r    <= CNT_W'(1);
            busy_r   <= 1'b1;
         end else if (busy_r) begin
            if (mplier_r[0]) begin
               acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign done    = done_r;
   assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential handshaked ALU with iterative multiplier.
// Define ALU_DIV_EN to add op 6 as an iterative unsigned restoring divider.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e             state_r;
   state_e             state_next;
   alu_op_e            op_s;
   logic               in_ready_s;
   logic               out_valid_s;
   logic               accept_s;
   logic               mul_start_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_product_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     diff_s;
   logic [WIDTH-1:0]   alu_result_s;
   logic [3:0]         alu_flags_s;
   logic               alu_error_s;
   logic               carry_s;
   logic               ovf_s;
   logic [WIDTH-1:0]   result_r;
   logic [3:0]         flags_r;
   logic               error_r;

   assign op_s        = alu_op_e'(bus.op);
   assign accept_s    = bus.in_valid && in_ready_s;
   assign mul_start_s = accept_s && (op_s == OP_MUL);
   assign sum_s       = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_s      = {1'b0, bus.a} - {1'b0, bus.b};

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start_s),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

`ifdef ALU_DIV_EN
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CNT_W-1:0] div_cnt_r;
   logic [WIDTH:0]   rem_shift_s;
   logic [WIDTH:0]   rem_diff_s;
   logic [WIDTH-1:0] rem_next_s;
   logic [WIDTH-1:0] quo_next_s;
   logic             div_start_s;
   logic             div_last_s;

   assign div_start_s = accept_s && (op_s == OP_DIV) && (bus.b != '0);
   assign div_last_s  = (state_r == DIV) && (div_cnt_r == CNT_W'(WIDTH - 1));
   assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
   assign rem_diff_s  = rem_shift_s - {1'b0, dvs_r};

   // Restoring step: keep the trial subtraction only when it did not go negative
   always_comb begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      if (!rem_diff_s[WIDTH]) begin
         rem_next_s = rem_diff_s[WIDTH-1:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_next_s = rem_shift_s[WIDTH-1:0];
      end
   end

   // Divider registers; dividend bits shift out of quo_r as quotient bits shift in
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_r     <= '0;
         quo_r     <= '0;
         dvs_r     <= '0;
         div_cnt_r <= '0;
      end else if (div_start_s) begin
         rem_r     <= '0;
         quo_r     <= bus.a;
         dvs_r     <= bus.b;
         div_cnt_r <= '0;
      end else if (state_r == DIV) begin
         rem_r     <= rem_next_s;
         quo_r     <= quo_next_s;
         div_cnt_r <= div_cnt_r + CNT_W'(1);
      end
   end
`endif

   // Single-cycle ops; invalid codes force result and flags to zero
   always_comb begin
      alu_result_s = '0;
      alu_error_s  = 1'b0;
      carry_s      = 1'b0;
      ovf_s        = 1'b0;
      alu_flags_s  = 4'b0000;
      case (op_s)
         OP_ADD: begin
            alu_result_s = sum_s[WIDTH-1:0];
            carry_s      = sum_s[WIDTH];
            ovf_s        = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_result_s = diff_s[WIDTH-1:0];
            carry_s      = diff_s[WIDTH];
            ovf_s        = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: alu_result_s = bus.a & bus.b;
         OP_XOR: alu_result_s = bus.a ^ bus.b;
         OP_OR:  alu_result_s = bus.a | bus.b;
         OP_MUL: alu_result_s = '0;
`ifdef ALU_DIV_EN
         OP_DIV: begin
            alu_result_s = '1;
            alu_error_s  = 1'b1;
         end
`endif
         default: alu_error_s = 1'b1;
      endcase
      if (alu_error_s && (alu_result_s == '0)) begin
         alu_flags_s = 4'b0000;
      end else begin
         alu_flags_s[FLAG_N] = alu_result_s[WIDTH-1];
         alu_flags_s[FLAG_Z] = (alu_result_s == '0);
         alu_flags_s[FLAG_C] = carry_s;
         alu_flags_s[FLAG_V] = ovf_s;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_next = IDLE;
            end else if (op_s == OP_MUL) begin
               state_next = MUL;
`ifdef ALU_DIV_EN
            end else if (div_start_s) begin
               state_next = DIV;
`endif
            end else begin
               state_next = DONE;
            end
         end
         MUL: begin
            if (mul_done_s) begin
               state_next = DONE;
            end else begin
               state_next = MUL;
            end
         end
`ifdef ALU_DIV_EN
         DIV: begin
            if (div_last_s) begin
               state_next = DONE;
            end else begin
               state_next = DIV;
            end
         end
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE:    in_ready_s  = 1'b1;
         DONE:    out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Result registers load once per command and hold through DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         result_r <= '0;
         flags_r  <= 4'b0000;
         error_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && (state_next == DONE)) begin
                  result_r <= alu_result_s;
                  flags_r  <= alu_flags_s;
                  error_r  <= alu_error_s;
               end
            end
            MUL: begin
               if (mul_done_s) begin
                  result_r        <= mul_product_s[WIDTH-1:0];
                  flags_r[FLAG_N] <= mul_product_s[WIDTH-1];
                  flags_r[FLAG_Z] <= (mul_product_s[WIDTH-1:0] == '0);
                  flags_r[FLAG_C] <= 1'b0;
                  flags_r[FLAG_V] <= (mul_product_s[2*WIDTH-1:WIDTH] != '0);
                  error_r         <= 1'b0;
               end
            end
`ifdef ALU_DIV_EN
            DIV: begin
               if (div_last_s) begin
                  result_r        <= quo_next_s;
                  flags_r[FLAG_N] <= quo_next_s[WIDTH-1];
                  flags_r[FLAG_Z] <= (quo_next_s == '0);
                  flags_r[FLAG_C] <= 1'b0;
                  flags_r[FLAG_V] <= 1'b0;
                  error_r         <= 1'b0;
               end
            end
`endif
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.result    = result_r;
   assign bus.flags     = flags_r;
   assign bus.error     = error_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; divider vectors run when ALU_DIV_EN is defined.
module tb_alu_seq;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   int   lat;
   int   seen_valid;

   alu_seq_if #(.WIDTH(16)) bus ();

   alu_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one command, then count cycles until out_valid (bounded)
   task automatic issue(input logic [2:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                        output int cycles);
      bus.in_valid  = 1'b1;
      bus.op        = op_v;
      bus.a         = a_v;
      bus.b         = b_v;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      cycles = 1;
      while (!bus.out_valid && cycles < 60) begin
         step();
         cycles++;
      end
   endtask

   task automatic retire(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq(tag, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 16'd0;
      bus.b         = 16'd0;
      bus.op        = 3'd0;
      step();
      step();
      reset = 1'b0;
      check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("rst_result", {16'd0, bus.result}, 32'd0);
      check_eq("rst_flags_err", {27'd0, bus.flags, bus.error}, 32'd0);

      issue(3'd0, 16'h7FFF, 16'h0001, lat);
      check_eq("add_lat", lat, 32'd1);
      check_eq("add_result", {16'd0, bus.result}, 32'h8000);
      check_eq("add_flags", {28'd0, bus.flags}, 32'b1001);
      retire("add_retire");

      issue(3'd4, 16'd3, 16'd5, lat);
      check_eq("sub_neg_result", {16'd0, bus.result}, 32'hFFFE);
      check_eq("sub_neg_flags", {28'd0, bus.flags}, 32'b1010);
      retire("sub_neg_retire");

      issue(3'd4, 16'd5, 16'd5, lat);
      check_eq("sub_zero_result", {16'd0, bus.result}, 32'd0);
      check_eq("sub_zero_flags", {28'd0, bus.flags}, 32'b0100);
      retire("sub_zero_retire");

      issue(3'd1, 16'd300, 16'd300, lat);
      check_eq("mul_lat", lat, 32'd17);
      check_eq("mul_big_result", {16'd0, bus.result}, 32'h5F90);
      check_eq("mul_big_flags", {28'd0, bus.flags}, 32'b0001);
      retire("mul_big_retire");

      issue(3'd1, 16'd12, 16'd11, lat);
      check_eq("mul_small_result", {16'd0, bus.result}, 32'd132);
      check_eq("mul_small_flags", {28'd0, bus.flags}, 32'b0000);
      retire("mul_small_retire");

      issue(3'd2, 16'hF0F0, 16'h0FF0, lat);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_hold", {14'd0, bus.in_ready, bus.out_valid, bus.result}, 32'h0001_00F0);
         step();
      end
      retire("bp_retire");

      issue(3'd3, 16'hFF00, 16'h0FF0, lat);
      check_eq("xor_result", {16'd0, bus.result}, 32'hF0F0);
      retire("xor_retire");

      issue(3'd5, 16'h8000, 16'h0001, lat);
      check_eq("or_flags", {12'd0, bus.result, bus.flags}, 32'h0008_0018);
      retire("or_retire");

      issue(3'd7, 16'h1234, 16'h5678, lat);
      check_eq("rsvd_lat", lat, 32'd1);
      check_eq("rsvd_out", {11'd0, bus.result, bus.flags, bus.error}, 32'h0000_0001);
      retire("rsvd_retire");

`ifdef ALU_DIV_EN
      issue(3'd6, 16'd100, 16'd7, lat);
      check_eq("div_lat", lat, 32'd17);
      check_eq("div_out", {15'd0, bus.result, bus.error}, {15'd0, 16'd14, 1'b0});
      retire("div_retire");

      issue(3'd6, 16'd55, 16'd0, lat);
      check_eq("div0_lat", lat, 32'd1);
      check_eq("div0_out", {15'd0, bus.result, bus.error}, {15'd0, 16'hFFFF, 1'b1});
      retire("div0_retire");
`else
      issue(3'd6, 16'd100, 16'd7, lat);
      check_eq("op6_lat", lat, 32'd1);
      check_eq("op6_out", {15'd0, bus.result, bus.error}, 32'd1);
      retire("op6_retire");
`endif

      // Leave a nonzero result, then abandon a multiply with reset
      issue(3'd0, 16'h0011, 16'h0022, lat);
      retire("pre_rst_retire");
      bus.in_valid = 1'b1;
      bus.op       = 3'd1;
      bus.a        = 16'd300;
      bus.b        = 16'd300;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
      check_eq("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("mrst_result", {16'd0, bus.result}, 32'd0);
      seen_valid = 0;
      for (int i = 0; i < 25; i++) begin
         if (bus.out_valid) seen_valid++;
         step();
      end
      check_eq("mrst_no_output", seen_valid, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
